mem_access_ctrl: RTL and testbench

Load/store initiator for the MIPS data RAM. It sits between the MEM pipeline stage and the word-wide data RAM. It accepts one load or store at a time from the pipeline and drives the RAM's write and read strobes, word address and write data. Byte and halfword accesses are performed as read-modify-write and aligned/sign-extended loads. It returns a one-cycle response carrying load data or a misalignment error.

---
 rtl/mips_mem_pkg.sv | 37 +++
 rtl/mem_access_ctrl_if.sv | 33 +++
 rtl/mem_lane_align.sv | 60 ++++++
 rtl/mem_access_ctrl.sv | 111 +++++++++++
 tb/tb_mem_access_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types for the MIPS data-RAM load/store controller.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RMW_RD,
    WR,
    RESP
  } state_t;

  // Request fields held for the whole access once accepted.
  typedef struct packed {
    size_t       size;
    logic        sgn;
    logic [1:0]  lane;
    logic [31:0] wdata;
  } req_t;

  // Reserved size, odd halfword, or word not on a 4-byte boundary.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = addr[0];
      SZ_WORD: is_misaligned = (addr != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Pipeline request/response plus data-RAM bus for mem_access_ctrl.
interface mem_access_ctrl_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [ADDR_WIDTH+1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;
  logic                  ram_we;
  logic                  ram_rd;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Controller side.
  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, ram_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, ram_we, ram_rd, ram_addr, ram_wdata
  );

  // Pipeline + RAM side.
  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, ram_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, ram_we, ram_rd, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_lane_align.sv
// Little-endian byte-lane logic: store merge and load extract/extend.
module mem_lane_align
  import mips_mem_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int VEC_W     = 8
) (
  input  logic [NUM_LANES-1:0][VEC_W-1:0] word,
  input  logic [NUM_LANES-1:0][VEC_W-1:0] wdata,
  input  size_t                           size,
  input  logic [1:0]                      lane,
  input  logic                            sgn,
  output logic [NUM_LANES-1:0][VEC_W-1:0] merged,
  output logic [NUM_LANES*VEC_W-1:0]      rdata
);
  localparam int W = NUM_LANES * VEC_W;

  for (genvar b = 0; b < NUM_LANES; b++) begin : g_lane
    localparam logic [1:0] LB = 2'(b);
    localparam int         HB = b % 2;
    logic             sel;
    logic [VEC_W-1:0] src;

    // Pick whether this byte is overwritten and from which store byte.
    always_comb begin
      sel = 1'b0;
      src = wdata[b];
      case (size)
        SZ_BYTE: begin sel = (lane == LB);       src = wdata[0];  end
        SZ_HALF: begin sel = (lane[1] == LB[1]); src = wdata[HB]; end
        SZ_WORD: begin sel = 1'b1;               src = wdata[b];  end
        default: begin sel = 1'b0;               src = wdata[b];  end
      endcase
    end

    assign merged[b] = sel ? src : word[b];
  end

  logic [W-1:0] flat;
  logic [W-1:0] sh;
  assign flat = word;

  // Shift the addressed lane down to bit 0, then extend.
  always_comb begin
    sh    = flat;
    rdata = flat;
    case (size)
      SZ_BYTE: begin
        sh    = flat >> {lane, 3'b000};
        rdata = {{(W-8){sgn & sh[7]}}, sh[7:0]};
      end
      SZ_HALF: begin
        sh    = flat >> {lane[1], 4'b0000};
        rdata = {{(W-16){sgn & sh[15]}}, sh[15:0]};
      end
      default: rdata = flat;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store initiator for the word-wide data RAM.
module mem_access_ctrl
  import mips_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input logic              clk,
  input logic              rst,
  mem_access_ctrl_if.slave bus
);
  state_t                st;
  req_t                  r;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] extracted;

  // Both lane paths work on the word the RAM is returning this cycle.
  mem_lane_align #(
    .NUM_LANES(DATA_WIDTH / 8),
    .VEC_W    (8)
  ) u_align (
    .word  (bus.ram_rdata),
    .wdata (r.wdata),
    .size  (r.size),
    .lane  (r.lane),
    .sgn   (r.sgn),
    .merged(merged),
    .rdata (extracted)
  );

  // Access sequencer; every output is a register set on the transition into its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      st             <= IDLE;
      r              <= '0;
      bus.req_ready  <= 1'b1;
      bus.ram_we     <= 1'b0;
      bus.ram_rd     <= 1'b0;
      bus.ram_addr   <= '0;
      bus.ram_wdata  <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (bus.req_valid) begin
            r.size        <= size_t'(bus.req_size);
            r.sgn         <= bus.req_signed;
            r.lane        <= bus.req_addr[1:0];
            r.wdata       <= bus.req_wdata;
            bus.ram_addr  <= bus.req_addr[ADDR_WIDTH+1:2];
            bus.req_ready <= 1'b0;
            if (is_misaligned(bus.req_size, bus.req_addr[1:0])) begin
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= '0;
              st             <= RESP;
            end else if (!bus.req_we) begin
              bus.ram_rd <= 1'b1;
              st         <= RD;
            end else if (bus.req_size == SZ_WORD) begin
              bus.ram_we    <= 1'b1;
              bus.ram_wdata <= bus.req_wdata;
              st            <= WR;
            end else begin
              // Sub-word store: fetch the word first so untouched bytes survive.
              bus.ram_rd <= 1'b1;
              st         <= RMW_RD;
            end
          end
        end
        RD: begin
          bus.ram_rd     <= 1'b0;
          bus.resp_valid <= 1'b1;
          bus.resp_rdata <= extracted;
          st             <= RESP;
        end
        RMW_RD: begin
          bus.ram_rd    <= 1'b0;
          bus.ram_we    <= 1'b1;
          bus.ram_wdata <= merged;
          st            <= WR;
        end
        WR: begin
          bus.ram_we     <= 1'b0;
          bus.resp_valid <= 1'b1;
          bus.resp_rdata <= '0;
          st             <= RESP;
        end
        RESP: begin
          bus.resp_valid <= 1'b0;
          bus.resp_err   <= 1'b0;
          bus.resp_rdata <= '0;
          bus.req_ready  <= 1'b1;
          st             <= IDLE;
        end
        default: begin
          bus.ram_we     <= 1'b0;
          bus.ram_rd     <= 1'b0;
          bus.resp_valid <= 1'b0;
          bus.resp_err   <= 1'b0;
          bus.resp_rdata <= '0;
          bus.req_ready  <= 1'b1;
          st             <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: byte-addressed reference memory vs. word RAM model.
module tb_mem_access_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_access_ctrl_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();

  mem_access_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // Word RAM model driven by the DUT; init_load copies init_img in one edge.
  logic [31:0] ram      [16];
  logic [31:0] init_img [16];
  logic        init_load = 1'b0;

  always @(posedge clk) begin
    if (init_load) begin
      for (int i = 0; i < 16; i++) ram[i] <= init_img[i];
    end else if (bus.ram_we) begin
      ram[bus.ram_addr] <= bus.ram_wdata;
    end
  end
  assign bus.ram_rdata = ram[bus.ram_addr];

  // Reference: plain byte array, little-endian.
  logic [7:0] ref_b [64];

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] last_rd;
  logic        last_err;
  logic [31:0] last_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_word(input int w);
    return {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
  endfunction

  task automatic load_image();
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 4; j++) ref_b[4*i+j] = init_img[i][8*j +: 8];
    @(negedge clk); init_load = 1'b1;
    @(negedge clk); init_load = 1'b0;
  endtask

  // Spec-level behaviour of one access; updates the reference memory for stores.
  task automatic ref_access(input logic we, input logic [1:0] sz, input logic sg,
                            input logic [5:0] ad, input logic [31:0] wd,
                            output logic [31:0] rd, output logic err,
                            output int lat, output int nrd, output int nwe);
    int n;
    n   = 1 << sz;
    err = (sz == 2'b11) || ((int'(ad) % n) != 0);
    rd  = 32'h0;
    if (err) begin
      lat = 1; nrd = 0; nwe = 0;
    end else if (we) begin
      for (int i = 0; i < n; i++) ref_b[int'(ad) + i] = wd[8*i +: 8];
      lat = (n == 4) ? 2 : 3;
      nrd = (n == 4) ? 0 : 1;
      nwe = 1;
    end else begin
      for (int i = 0; i < n; i++) rd = rd | (32'(ref_b[int'(ad) + i]) << (8*i));
      if (sg && n < 4 && rd[8*n-1]) rd = rd | (32'hFFFF_FFFF << (8*n));
      lat = 2; nrd = 1; nwe = 0;
    end
  endtask

  task automatic run_op(input string tag, input logic we, input logic [1:0] sz, input logic sg,
                        input logic [5:0] ad, input logic [31:0] wd);
    logic [31:0] exp_rd;
    logic        exp_err;
    int exp_lat, exp_nrd, exp_nwe;
    int lat, nrd, nwe, ovl, badaddr, k;
    logic got;
    ref_access(we, sz, sg, ad, wd, exp_rd, exp_err, exp_lat, exp_nrd, exp_nwe);
    k = 0;
    while (!bus.req_ready && k < 20) begin @(negedge clk); k++; end
    chk($sformatf("%s.ready", tag), 32'(bus.req_ready), 32'd1);
    bus.req_we = we; bus.req_size = sz; bus.req_signed = sg;
    bus.req_addr = ad; bus.req_wdata = wd; bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_wdata = $urandom;
    lat = 1; nrd = 0; nwe = 0; ovl = 0; badaddr = 0; got = 1'b0;
    last_rd = 32'hx; last_err = 1'bx;
    while (lat <= 8) begin
      if (bus.ram_rd && bus.ram_we) ovl++;
      if (bus.ram_rd) nrd++;
      if (bus.ram_we) begin nwe++; last_wdata = bus.ram_wdata; end
      if ((bus.ram_rd || bus.ram_we) && bus.ram_addr !== ad[5:2]) badaddr++;
      if (bus.resp_valid) begin
        got = 1'b1; last_rd = bus.resp_rdata; last_err = bus.resp_err;
        break;
      end
      @(negedge clk);
      lat++;
    end
    chk($sformatf("%s.resp_seen", tag), 32'(got), 32'd1);
    chk($sformatf("%s.latency", tag), 32'(lat), 32'(exp_lat));
    chk($sformatf("%s.rdata", tag), last_rd, exp_rd);
    chk($sformatf("%s.err", tag), 32'(last_err), 32'(exp_err));
    chk($sformatf("%s.n_rd", tag), 32'(nrd), 32'(exp_nrd));
    chk($sformatf("%s.n_we", tag), 32'(nwe), 32'(exp_nwe));
    chk($sformatf("%s.excl", tag), 32'(ovl), 32'd0);
    chk($sformatf("%s.addr", tag), 32'(badaddr), 32'd0);
    @(negedge clk);
    chk($sformatf("%s.post_valid", tag), 32'(bus.resp_valid), 32'd0);
    chk($sformatf("%s.post_rdata", tag), bus.resp_rdata | 32'(bus.resp_err), 32'd0);
    chk($sformatf("%s.post_ready", tag), 32'(bus.req_ready), 32'd1);
    chk($sformatf("%s.ram", tag), ram[ad[5:2]], ref_word(int'(ad[5:2])));
  endtask

  initial begin
    int k, n, cyc, ovl;
    int acc [3];
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    for (int i = 0; i < 16; i++) init_img[i] = $urandom;
    load_image();
    @(negedge clk);
    // Reset state.
    chk("rst.ready", 32'(bus.req_ready), 32'd1);
    chk("rst.strobes", {30'd0, bus.ram_we, bus.ram_rd}, 32'd0);
    chk("rst.addr", 32'(bus.ram_addr), 32'd0);
    chk("rst.wdata", bus.ram_wdata, 32'd0);
    chk("rst.resp", {30'd0, bus.resp_valid, bus.resp_err}, 32'd0);
    chk("rst.rdata", bus.resp_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed: word load.
    init_img[3] = 32'h0000_0021; load_image();
    run_op("wload", 1'b0, 2'b10, 1'b0, 6'h0C, 32'h0);
    chk("wload.lit", last_rd, 32'h0000_0021);

    // Directed: byte store RMW.
    init_img[3] = 32'h1122_3344; load_image();
    run_op("bstore", 1'b1, 2'b00, 1'b0, 6'h0D, 32'h0000_00AB);
    chk("bstore.wdata", last_wdata, 32'h1122_AB44);
    chk("bstore.lit", ram[3], 32'h1122_AB44);

    // Directed: signed / unsigned byte load.
    init_img[3] = 32'h0080_0000; load_image();
    run_op("sbload", 1'b0, 2'b00, 1'b1, 6'h0E, 32'h0);
    chk("sbload.lit", last_rd, 32'hFFFF_FF80);
    run_op("ubload", 1'b0, 2'b00, 1'b0, 6'h0E, 32'h0);
    chk("ubload.lit", last_rd, 32'h0000_0080);

    // Directed: errors.
    run_op("mis_word", 1'b0, 2'b10, 1'b0, 6'h06, 32'h0);
    chk("mis_word.lit", 32'(last_err), 32'd1);
    run_op("rsvd", 1'b1, 2'b11, 1'b0, 6'h08, 32'hDEAD_BEEF);
    chk("rsvd.lit", 32'(last_err), 32'd1);
    run_op("mis_half", 1'b1, 2'b01, 1'b0, 6'h03, 32'h1234);

    // Randomized accesses, weighted towards legal ones.
    for (int i = 0; i < 60; i++) begin
      logic [1:0] sz;
      logic [5:0] ad;
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      ad = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) ad = ad & ~6'((1 << sz) - 1);
      run_op($sformatf("rnd%0d", i), 1'($urandom), sz, 1'($urandom), ad, $urandom);
    end

    // Reset during RMW_RD of a half store: no write, no response.
    k = 0;
    while (!bus.req_ready && k < 20) begin @(negedge clk); k++; end
    bus.req_we = 1'b1; bus.req_size = 2'b01; bus.req_signed = 1'b0;
    bus.req_addr = 6'h08; bus.req_wdata = 32'h0000_5A5A; bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rstmid.in_rmw", 32'(bus.ram_rd), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid.ready", 32'(bus.req_ready), 32'd1);
    chk("rstmid.strobes", {30'd0, bus.ram_we, bus.ram_rd}, 32'd0);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.resp_valid || bus.ram_we) n++;
      @(negedge clk);
    end
    chk("rstmid.quiet", 32'(n), 32'd0);
    chk("rstmid.ram", ram[2], ref_word(2));

    // Back-to-back word loads with req_valid held high.
    bus.req_we = 1'b0; bus.req_size = 2'b10; bus.req_signed = 1'b0;
    bus.req_addr = 6'h10; bus.req_valid = 1'b1;
    n = 0; cyc = 0; ovl = 0;
    acc[0] = 0; acc[1] = 0; acc[2] = 0;
    while (n < 3 && cyc < 30) begin
      if (bus.ram_rd && bus.ram_we) ovl++;
      if (bus.resp_valid) chk("b2b.rdata", bus.resp_rdata, ref_word(4));
      if (bus.req_ready) begin acc[n] = cyc; n++; end
      @(negedge clk);
      cyc++;
    end
    bus.req_valid = 1'b0;
    k = 0;
    while (!bus.req_ready && k < 20) begin
      if (bus.ram_rd && bus.ram_we) ovl++;
      if (bus.resp_valid) chk("b2b.rdata", bus.resp_rdata, ref_word(4));
      @(negedge clk); k++;
    end
    chk("b2b.count", 32'(n), 32'd3);
    chk("b2b.gap01", 32'(acc[1] - acc[0]), 32'd3);
    chk("b2b.gap12", 32'(acc[2] - acc[1]), 32'd3);
    chk("b2b.excl", 32'(ovl), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
